uart_word_link: RTL and testbench
=================================

// Module: uart_word_link
// PURPOSE
//  Parametrised UART core that packs WORD_BYTES received characters into one word and serialises a word back out.
//  Adds a runtime baud divisor, optional parity, and sticky parity/framing/overrun error flags.
//  Word-level valid/ack and load/busy handshakes sit between the serial pins and the cipher datapath.
//  Single self-contained module: baud tick, RX FSM, TX FSM and packing logic.
// PARAMETERS
//  DBITS      8   data bits per character
//  SB_TICK    16  oversample ticks in the stop period (16 = 1 stop bit, 32 = 2 stop bits)
//  WORD_BYTES 8   characters per word; W = WORD_BYTES*DBITS
//  DIV_BITS   13  width of baud_div
//  PARITY_EN  0   1 = parity bit after data, on both RX and TX
//  PARITY_ODD 0   1 = odd parity, 0 = even parity
// PORTS
//  clk_100MHz    in  1         system clock
//  reset         in  1         synchronous, active-high
//  baud_div      in  DIV_BITS  clocks per 16x oversample tick; values <2 are treated as 2
//  rx            in  1         serial in (asynchronous)
//  tx            out 1         serial out, idles high
//  rx_word       out W         assembled word; first character received is in the MS byte
//  rx_word_valid out 1         high while rx_word is unacknowledged
//  rx_word_ack   in  1         consumes rx_word
//  rx_byte_count out $clog2(WORD_BYTES)+1  characters in the partial word
//  tx_word       in  W         word to send, MS byte first
//  tx_word_load  in  1         capture tx_word; ignored while tx_busy
//  tx_busy       out 1         a word is being transmitted
//  tx_word_done  out 1         1-cycle pulse after the last stop bit
//  parity_err    out 1         sticky error flag
//  frame_err     out 1         sticky error flag
//  overrun_err   out 1         sticky error flag
//  err_clear     in  1         clears all sticky flags
// BEHAVIOUR
//  Reset (values by next edge; aborts any frame in progress):
//   - tx=1; tx_busy, tx_word_done, rx_word_valid, rx_word, rx_byte_count and all flags = 0.
//   - Both FSMs go to IDLE; the tick counter goes to 0.
//  Baud tick:
//   - Counter runs 0..baud_div-1; tick is high for 1 cycle at wrap.
//   - A change to baud_div takes effect at the next wrap.
//  Framing:
//   - Bits go LSB first; one bit = 16 ticks.
//   - Parity bit = ^data for even parity, ~^data for odd parity.
//  RX input: rx passes through a 2-flop synchroniser, reset value 1.
//  RX FSM IDLE->START->DATA->(PARITY)->STOP->IDLE:
//   - IDLE: synced rx==0 -> START, tick count cleared.
//   - START: at tick 7, rx still 0 -> DATA; otherwise glitch -> IDLE with nothing recorded.
//   - DATA/PARITY: sample at tick 15 of each bit.
//   - STOP: sample at tick SB_TICK-1.
//     - Sample 0 -> set frame_err, discard the character.
//     - Parity mismatch -> set parity_err, discard the character.
//     - Otherwise accept: shift into the assembly register, rx_byte_count+1.
//  Word completion (count reaches WORD_BYTES):
//   - Count returns to 0. If valid==0, or ack is high the same cycle, load rx_word and set valid.
//   - Otherwise set overrun_err, drop the new word, leave rx_word unchanged.
//   - ack with valid=1 and no completion -> valid=0 next cycle.
//  TX FSM IDLE->START->DATA->(PARITY)->STOP, repeated WORD_BYTES times:
//   - load in IDLE: capture tx_word; tx_busy=1 next cycle; start bit begins at the next tick.
//   - Characters are back-to-back with no idle gap.
//   - After the final stop period: tx_word_done pulses and tx_busy=0 in the same cycle.
//   - A new load is accepted the following cycle.
//  Error flags:
//   - err_clear drops all flags next cycle.
//   - An error event coincident with err_clear wins; that flag stays 1.
// TESTING (baud_div=4: 1 bit = 64 clocks)
//  - Send 8 chars "SIMONSAY" -> rx_word=64'h53494D4F4E534159 and valid=1 after the 8th stop; ack -> valid=0 next cycle.
//  - Load 64'h0123456789ABCDEF -> tx frames 0x01..0xEF MS byte first, 8 frames x 640 clocks, then done pulse with busy=0.
//  - PARITY_EN=1, PARITY_ODD=0: send 0x41 with parity bit 1 -> parity_err=1, count unchanged; err_clear -> parity_err=0.
//  - Stop bit forced 0 on the 3rd char -> frame_err=1, rx_byte_count stays 2.
//  - Two full words without ack -> overrun_err=1, rx_word holds the first word.
//    Completion coincident with ack -> second word loaded, no overrun.
//  - 1-tick low rx glitch -> no state change.
//    reset asserted mid-TX frame -> tx=1 and busy=0 next cycle.
//    load during busy -> ignored.

Source files
------------

// File: rtl/uart_word_link.sv
// UART core that packs WORD_BYTES received characters into one word and
// serialises a word back out, with a runtime baud divisor, optional parity
// and sticky parity/framing/overrun flags.
// Ports:
//   clk_100MHz, reset         clock, synchronous active-high reset
//   baud_div                  clocks per 16x oversample tick (<2 treated as 2)
//   rx / tx                   serial pins (tx idles high)
//   rx_word, rx_word_valid,
//   rx_word_ack               received word handshake (first char in MS byte)
//   rx_byte_count             characters held in the partial word
//   tx_word, tx_word_load,
//   tx_busy, tx_word_done     transmit word handshake (MS byte sent first)
//   parity_err, frame_err,
//   overrun_err, err_clear    sticky error flags and their clear
module uart_word_link #(
  parameter int unsigned DBITS      = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned WORD_BYTES = 8,
  parameter int unsigned DIV_BITS   = 13,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                          clk_100MHz,
  input  logic                          reset,
  input  logic [DIV_BITS-1:0]           baud_div,
  input  logic                          rx,
  output logic                          tx,
  output logic [WORD_BYTES*DBITS-1:0]   rx_word,
  output logic                          rx_word_valid,
  input  logic                          rx_word_ack,
  output logic [$clog2(WORD_BYTES):0]   rx_byte_count,
  input  logic [WORD_BYTES*DBITS-1:0]   tx_word,
  input  logic                          tx_word_load,
  output logic                          tx_busy,
  output logic                          tx_word_done,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun_err,
  input  logic                          err_clear
);

  localparam int unsigned W  = WORD_BYTES * DBITS;
  localparam int unsigned CW = $clog2(WORD_BYTES) + 1;
  localparam int unsigned TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = (DBITS > 1) ? $clog2(DBITS) : 1;

  // Baud tick: the divisor in use is only re-sampled at wrap
  logic [DIV_BITS-1:0] div_cnt, div_cur, div_eff_c;
  logic                tick;

  assign div_eff_c = (baud_div < DIV_BITS'(2)) ? DIV_BITS'(2) : baud_div;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      div_cnt <= '0;
      div_cur <= div_eff_c;
      tick    <= 1'b0;
    end else if (div_cnt == div_cur - DIV_BITS'(1)) begin
      div_cnt <= '0;
      div_cur <= div_eff_c;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_BITS'(1);
      tick    <= 1'b0;
    end
  end

  // Two-flop synchroniser for the asynchronous rx pin
  logic rx_meta, rx_sync;
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // RX FSM
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;
  rx_state_t        rx_state, rx_state_n;
  logic [TW-1:0]    rx_s, rx_s_n;
  logic [NW-1:0]    rx_n, rx_n_n;
  logic [DBITS-1:0] rx_b, rx_b_n;
  logic             rx_p, rx_p_n;
  logic             rx_done_c, rx_ferr_c, rx_perr_c, rx_ovr_c;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rx_state <= R_IDLE;
      rx_s     <= '0;
      rx_n     <= '0;
      rx_b     <= '0;
      rx_p     <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_s     <= rx_s_n;
      rx_n     <= rx_n_n;
      rx_b     <= rx_b_n;
      rx_p     <= rx_p_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_s_n     = rx_s;
    rx_n_n     = rx_n;
    rx_b_n     = rx_b;
    rx_p_n     = rx_p;
    rx_done_c  = 1'b0;
    rx_ferr_c  = 1'b0;
    rx_perr_c  = 1'b0;
    unique case (rx_state)
      R_IDLE: begin
        if (!rx_sync) begin
          rx_state_n = R_START;
          rx_s_n     = '0;
        end
      end
      R_START: begin
        // Mid start bit: a high line here was only a glitch
        if (tick) begin
          if (rx_s == TW'(7)) begin
            if (!rx_sync) begin
              rx_state_n = R_DATA;
              rx_s_n     = '0;
              rx_n_n     = '0;
            end else begin
              rx_state_n = R_IDLE;
            end
          end else begin
            rx_s_n = rx_s + TW'(1);
          end
        end
      end
      R_DATA: begin
        if (tick) begin
          if (rx_s == TW'(15)) begin
            rx_s_n = '0;
            rx_b_n = {rx_sync, rx_b[DBITS-1:1]};
            if (rx_n == NW'(DBITS - 1)) begin
              rx_state_n = (PARITY_EN != 0) ? R_PAR : R_STOP;
            end else begin
              rx_n_n = rx_n + NW'(1);
            end
          end else begin
            rx_s_n = rx_s + TW'(1);
          end
        end
      end
      R_PAR: begin
        if (tick) begin
          if (rx_s == TW'(15)) begin
            rx_s_n     = '0;
            rx_p_n     = rx_sync;
            rx_state_n = R_STOP;
          end else begin
            rx_s_n = rx_s + TW'(1);
          end
        end
      end
      R_STOP: begin
        // Framing error takes precedence over a parity error
        if (tick) begin
          if (rx_s == TW'(SB_TICK - 1)) begin
            rx_state_n = R_IDLE;
            if (!rx_sync) begin
              rx_ferr_c = 1'b1;
            end else if ((PARITY_EN != 0) && (rx_p != ((^rx_b) ^ 1'(PARITY_ODD)))) begin
              rx_perr_c = 1'b1;
            end else begin
              rx_done_c = 1'b1;
            end
          end else begin
            rx_s_n = rx_s + TW'(1);
          end
        end
      end
      default: rx_state_n = R_IDLE;
    endcase
  end

  // Word packing and the valid/ack handshake
  logic [W-1:0] rx_asm, rx_full_c;
  logic         rx_last_c;

  assign rx_full_c = {rx_asm[W-DBITS-1:0], rx_b};
  assign rx_last_c = (rx_byte_count == CW'(WORD_BYTES - 1));
  assign rx_ovr_c  = rx_done_c && rx_last_c && rx_word_valid && !rx_word_ack;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rx_asm        <= '0;
      rx_byte_count <= '0;
      rx_word       <= '0;
      rx_word_valid <= 1'b0;
    end else if (rx_done_c && rx_last_c) begin
      rx_asm        <= rx_full_c;
      rx_byte_count <= '0;
      if (!rx_word_valid || rx_word_ack) begin
        rx_word       <= rx_full_c;
        rx_word_valid <= 1'b1;
      end
    end else begin
      if (rx_done_c) begin
        rx_asm        <= rx_full_c;
        rx_byte_count <= rx_byte_count + CW'(1);
      end
      if (rx_word_ack) begin
        rx_word_valid <= 1'b0;
      end
    end
  end

  // Sticky flags: a new event outranks a simultaneous clear
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      parity_err  <= (parity_err  & ~err_clear) | rx_perr_c;
      frame_err   <= (frame_err   & ~err_clear) | rx_ferr_c;
      overrun_err <= (overrun_err & ~err_clear) | rx_ovr_c;
    end
  end

  // TX FSM; T_WAIT aligns the first start bit to a baud tick
  typedef enum logic [2:0] {T_IDLE, T_WAIT, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  tx_state_t        tx_state, tx_state_n;
  logic [TW-1:0]    tx_s, tx_s_n;
  logic [NW-1:0]    tx_n, tx_n_n;
  logic [DBITS-1:0] tx_d, tx_d_n;
  logic             tx_p, tx_p_n;
  logic [W-1:0]     tx_sh, tx_sh_n;
  logic [CW-1:0]    tx_chr, tx_chr_n;
  logic             tx_line_n, tx_busy_n, tx_done_n;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      tx_state     <= T_IDLE;
      tx_s         <= '0;
      tx_n         <= '0;
      tx_d         <= '0;
      tx_p         <= 1'b0;
      tx_sh        <= '0;
      tx_chr       <= '0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_word_done <= 1'b0;
    end else begin
      tx_state     <= tx_state_n;
      tx_s         <= tx_s_n;
      tx_n         <= tx_n_n;
      tx_d         <= tx_d_n;
      tx_p         <= tx_p_n;
      tx_sh        <= tx_sh_n;
      tx_chr       <= tx_chr_n;
      tx           <= tx_line_n;
      tx_busy      <= tx_busy_n;
      tx_word_done <= tx_done_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_s_n     = tx_s;
    tx_n_n     = tx_n;
    tx_d_n     = tx_d;
    tx_p_n     = tx_p;
    tx_sh_n    = tx_sh;
    tx_chr_n   = tx_chr;
    tx_busy_n  = tx_busy;
    tx_done_n  = 1'b0;
    tx_line_n  = 1'b1;
    unique case (tx_state)
      T_IDLE: begin
        if (tx_word_load) begin
          tx_sh_n    = tx_word;
          tx_chr_n   = '0;
          tx_busy_n  = 1'b1;
          tx_state_n = T_WAIT;
        end
      end
      T_WAIT: begin
        if (tick) begin
          tx_state_n = T_START;
          tx_s_n     = '0;
          tx_d_n     = tx_sh[W-1 -: DBITS];
          tx_sh_n    = tx_sh << DBITS;
          tx_p_n     = 1'(PARITY_ODD);
        end
      end
      T_START: begin
        if (tick) begin
          if (tx_s == TW'(15)) begin
            tx_s_n     = '0;
            tx_n_n     = '0;
            tx_state_n = T_DATA;
          end else begin
            tx_s_n = tx_s + TW'(1);
          end
        end
      end
      T_DATA: begin
        // Parity accumulates as each data bit leaves the shifter
        if (tick) begin
          if (tx_s == TW'(15)) begin
            tx_s_n = '0;
            tx_p_n = tx_p ^ tx_d[0];
            tx_d_n = tx_d >> 1;
            if (tx_n == NW'(DBITS - 1)) begin
              tx_state_n = (PARITY_EN != 0) ? T_PAR : T_STOP;
            end else begin
              tx_n_n = tx_n + NW'(1);
            end
          end else begin
            tx_s_n = tx_s + TW'(1);
          end
        end
      end
      T_PAR: begin
        if (tick) begin
          if (tx_s == TW'(15)) begin
            tx_s_n     = '0;
            tx_state_n = T_STOP;
          end else begin
            tx_s_n = tx_s + TW'(1);
          end
        end
      end
      T_STOP: begin
        // Next character follows the stop period with no idle gap
        if (tick) begin
          if (tx_s == TW'(SB_TICK - 1)) begin
            tx_s_n = '0;
            if (tx_chr == CW'(WORD_BYTES - 1)) begin
              tx_state_n = T_IDLE;
              tx_done_n  = 1'b1;
              tx_busy_n  = 1'b0;
            end else begin
              tx_chr_n   = tx_chr + CW'(1);
              tx_state_n = T_START;
              tx_d_n     = tx_sh[W-1 -: DBITS];
              tx_sh_n    = tx_sh << DBITS;
              tx_p_n     = 1'(PARITY_ODD);
            end
          end else begin
            tx_s_n = tx_s + TW'(1);
          end
        end
      end
      default: tx_state_n = T_IDLE;
    endcase
    case (tx_state_n)
      T_START: tx_line_n = 1'b0;
      T_DATA:  tx_line_n = tx_d_n[0];
      T_PAR:   tx_line_n = tx_p_n;
      default: tx_line_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_word_link.sv
// Scoreboard bench for uart_word_link (8 data bits, 8-char words, even parity).
module tb_uart_word_link;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] baud_div;
  logic        rx;
  logic        tx;
  logic [63:0] rx_word;
  logic        rx_word_valid;
  logic        rx_word_ack;
  logic [3:0]  rx_byte_count;
  logic [63:0] tx_word;
  logic        tx_word_load;
  logic        tx_busy;
  logic        tx_word_done;
  logic        parity_err, frame_err, overrun_err;
  logic        err_clear;

  always #5 clk = ~clk;

  uart_word_link #(
    .DBITS(8), .SB_TICK(16), .WORD_BYTES(8), .DIV_BITS(13),
    .PARITY_EN(1), .PARITY_ODD(0)
  ) dut (
    .clk_100MHz(clk), .reset(reset), .baud_div(baud_div), .rx(rx), .tx(tx),
    .rx_word(rx_word), .rx_word_valid(rx_word_valid), .rx_word_ack(rx_word_ack),
    .rx_byte_count(rx_byte_count), .tx_word(tx_word), .tx_word_load(tx_word_load),
    .tx_busy(tx_busy), .tx_word_done(tx_word_done), .parity_err(parity_err),
    .frame_err(frame_err), .overrun_err(overrun_err), .err_clear(err_clear)
  );

  int errors = 0;
  int checks = 0;
  int bit_clk = 64;
  bit auto_ack = 1'b1;
  bit tx_mon_en = 1'b1;
  logic mon_ack = 1'b0;
  logic man_ack = 1'b0;
  assign rx_word_ack = mon_ack | man_ack;

  logic [63:0] rx_exp_q[$];
  logic [63:0] tx_exp_q[$];
  logic [7:0]  acc_q[$];
  logic [7:0]  tx_got_q[$];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Reference model: accepted characters gather into words, first char in MS byte
  function automatic void model_accept(input logic [7:0] d);
    logic [63:0] w;
    acc_q.push_back(d);
    if (acc_q.size() == 8) begin
      w = '0;
      foreach (acc_q[i]) w = {w[55:0], acc_q[i]};
      rx_exp_q.push_back(w);
      acc_q.delete();
    end
  endfunction

  task automatic set_div(input int d);
    baud_div = 13'(d);
    bit_clk  = 16 * ((d < 2) ? 2 : d);
    repeat (16) @(negedge clk);
  endtask

  // One character on rx plus a one-bit idle gap; a bad stop is held low past mid-bit
  task automatic send_char(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    rx = 1'b0;
    repeat (bit_clk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (bit_clk) @(negedge clk);
    end
    rx = (^d) ^ bad_par;
    repeat (bit_clk) @(negedge clk);
    if (bad_stop) begin
      rx = 1'b0;
      repeat (bit_clk * 3 / 4) @(negedge clk);
      rx = 1'b1;
      repeat (bit_clk / 4) @(negedge clk);
    end else begin
      rx = 1'b1;
      repeat (bit_clk) @(negedge clk);
    end
    rx = 1'b1;
    repeat (bit_clk) @(negedge clk);
  endtask

  task automatic send_word(input logic [63:0] w, input bit use_model);
    for (int i = 7; i >= 0; i--) begin
      if (use_model) model_accept(w[i*8 +: 8]);
      send_char(w[i*8 +: 8], 1'b0, 1'b0);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (rx_exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("rx_queue_drained", 64'(rx_exp_q.size()), 64'd0);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    @(negedge clk);
  endtask

  // RX monitor: compare each presented word, ack it, expect valid to drop
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack && rx_word_valid) begin
        if (rx_exp_q.size() == 0) begin
          chk("rx_unexpected_word", rx_word, 64'hx);
        end else begin
          chk("rx_word", rx_word, rx_exp_q.pop_front());
        end
        mon_ack = 1'b1;
        @(negedge clk);
        mon_ack = 1'b0;
        chk("rx_valid_after_ack", 64'(rx_word_valid), 64'd0);
      end
    end
  end

  // TX line decoder: sample mid-bit, check framing and parity
  logic [7:0] dec_d;
  logic       dec_st, dec_p, dec_sp;
  initial begin
    forever begin
      @(negedge clk);
      if (tx_mon_en && tx === 1'b0) begin
        repeat (bit_clk / 2) @(negedge clk);
        dec_st = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (bit_clk) @(negedge clk);
          dec_d[i] = tx;
        end
        repeat (bit_clk) @(negedge clk);
        dec_p = tx;
        repeat (bit_clk) @(negedge clk);
        dec_sp = tx;
        if (tx_mon_en) begin
          chk("tx_start_bit", 64'(dec_st), 64'd0);
          chk("tx_parity_bit", 64'(dec_p), 64'(^dec_d));
          chk("tx_stop_bit", 64'(dec_sp), 64'd1);
          tx_got_q.push_back(dec_d);
        end
      end
    end
  end

  // TX done monitor: compare the decoded word with the scoreboard
  logic [63:0] got_w;
  initial begin
    forever begin
      @(negedge clk);
      if (tx_word_done) begin
        chk("tx_busy_at_done", 64'(tx_busy), 64'd0);
        if (tx_exp_q.size() == 0) begin
          chk("tx_unexpected_done", 64'd1, 64'd0);
        end else begin
          got_w = '0;
          if (tx_got_q.size() < 8) begin
            got_w = 'x;
          end else begin
            repeat (8) got_w = {got_w[55:0], tx_got_q.pop_front()};
          end
          tx_got_q.delete();
          chk("tx_word", got_w, tx_exp_q.pop_front());
        end
        @(negedge clk);
        chk("tx_done_width", 64'(tx_word_done), 64'd0);
      end
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    string       simon;
    logic [63:0] wa, wb, wc, w;
    int          cyc;

    simon = "SIMONSAY";
    reset = 1'b1; rx = 1'b1; baud_div = 13'd4; tx_word = '0;
    tx_word_load = 1'b0; err_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_busy", 64'(tx_busy), 64'd0);
    chk("rst_done", 64'(tx_word_done), 64'd0);
    chk("rst_valid", 64'(rx_word_valid), 64'd0);
    chk("rst_rx_word", rx_word, 64'd0);
    chk("rst_count", 64'(rx_byte_count), 64'd0);
    chk("rst_flags", {61'd0, parity_err, frame_err, overrun_err}, 64'd0);
    reset = 1'b0;
    set_div(4);

    // Known word in, monitor acks it
    for (int i = 0; i < 8; i++) begin
      model_accept(simon[i]);
      send_char(simon[i], 1'b0, 1'b0);
    end
    wait_drain();
    chk("rx_word_simon", rx_word, 64'h53494D4F4E534159);
    chk("count_after_word", 64'(rx_byte_count), 64'd0);

    // Known word out, with a second load ignored while busy
    tx_exp_q.push_back(64'h0123456789ABCDEF);
    tx_word = 64'h0123456789ABCDEF;
    tx_word_load = 1'b1;
    @(negedge clk);
    tx_word_load = 1'b0;
    cyc = 1;
    chk("tx_busy_after_load", 64'(tx_busy), 64'd1);
    repeat (100) @(negedge clk);
    tx_word = 64'hFEDCBA9876543210;
    tx_word_load = 1'b1;
    @(negedge clk);
    tx_word_load = 1'b0;
    cyc += 101;
    while (!tx_word_done && cyc < 8000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc < 5632 || cyc > 5640) begin
      errors++;
      $display("FAIL tx_duration: got %0d cycles expected 5632..5640", cyc);
    end
    repeat (2 * bit_clk) @(negedge clk);
    chk("tx_idle_after_word", 64'(tx_busy), 64'd0);
    chk("tx_queue_drained", 64'(tx_exp_q.size()), 64'd0);

    // Random words in
    set_div(2);
    for (int k = 0; k < 3; k++) begin
      w = {$urandom, $urandom};
      for (int i = 7; i >= 0; i--) begin
        model_accept(w[i*8 +: 8]);
        send_char(w[i*8 +: 8], 1'b0, 1'b0);
        chk("rx_count_progress", 64'(rx_byte_count), 64'(acc_q.size()));
      end
    end
    wait_drain();

    // Parity and framing errors inside a partial word
    for (int i = 0; i < 2; i++) begin
      w[7:0] = 8'($urandom);
      model_accept(w[7:0]);
      send_char(w[7:0], 1'b0, 1'b0);
    end
    chk("count_two", 64'(rx_byte_count), 64'(acc_q.size()));
    send_char(8'h41, 1'b1, 1'b0);
    chk("parity_err_set", 64'(parity_err), 64'd1);
    chk("count_after_perr", 64'(rx_byte_count), 64'(acc_q.size()));
    pulse_clear();
    chk("parity_err_cleared", 64'(parity_err), 64'd0);
    send_char(8'($urandom), 1'b0, 1'b1);
    chk("frame_err_set", 64'(frame_err), 64'd1);
    chk("parity_err_quiet", 64'(parity_err), 64'd0);
    chk("count_after_ferr", 64'(rx_byte_count), 64'(acc_q.size()));
    for (int i = 0; i < 6; i++) begin
      w[7:0] = 8'($urandom);
      model_accept(w[7:0]);
      send_char(w[7:0], 1'b0, 1'b0);
    end
    wait_drain();
    pulse_clear();
    chk("frame_err_cleared", 64'(frame_err), 64'd0);

    // One-tick glitch leaves nothing behind
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2 * bit_clk) @(negedge clk);
    chk("glitch_count", 64'(rx_byte_count), 64'd0);
    chk("glitch_valid", 64'(rx_word_valid), 64'd0);
    chk("glitch_flags", {61'd0, parity_err, frame_err, overrun_err}, 64'd0);

    // Overrun: second word without ack is dropped
    auto_ack = 1'b0;
    wa = {$urandom, $urandom};
    wb = {$urandom, $urandom};
    send_word(wa, 1'b0);
    chk("ovr_first_valid", 64'(rx_word_valid), 64'd1);
    chk("ovr_first_word", rx_word, wa);
    chk("ovr_flag_quiet", 64'(overrun_err), 64'd0);
    send_word(wb, 1'b0);
    chk("ovr_flag_set", 64'(overrun_err), 64'd1);
    chk("ovr_word_held", rx_word, wa);
    chk("ovr_valid_held", 64'(rx_word_valid), 64'd1);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    chk("ovr_valid_after_ack", 64'(rx_word_valid), 64'd0);
    auto_ack = 1'b1;
    wc = {$urandom, $urandom};
    send_word(wc, 1'b1);
    wait_drain();
    chk("ovr_next_word", rx_word, wc);
    pulse_clear();
    chk("overrun_cleared", 64'(overrun_err), 64'd0);

    // baud_div below 2 behaves as 2
    set_div(0);
    w = {$urandom, $urandom};
    tx_exp_q.push_back(w);
    tx_word = w;
    tx_word_load = 1'b1;
    @(negedge clk);
    tx_word_load = 1'b0;
    cyc = 0;
    while (!tx_word_done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc < 2816 || cyc > 2822) begin
      errors++;
      $display("FAIL tx_duration_div0: got %0d cycles expected 2816..2822", cyc);
    end
    repeat (2 * bit_clk) @(negedge clk);
    chk("tx_queue_drained_div0", 64'(tx_exp_q.size()), 64'd0);

    // Reset in the middle of a frame
    tx_mon_en = 1'b0;
    tx_word = {$urandom, $urandom};
    tx_word_load = 1'b1;
    @(negedge clk);
    tx_word_load = 1'b0;
    repeat (200) @(negedge clk);
    chk("busy_before_reset", 64'(tx_busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid_tx_line", 64'(tx), 64'd1);
    chk("reset_mid_tx_busy", 64'(tx_busy), 64'd0);
    repeat (4 * bit_clk) @(negedge clk);
    chk("reset_mid_tx_stays_idle", 64'(tx_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
